// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions.
//   INSTR_W          : instruction / address width
//   PC_STEP          : sequential fetch increment
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_state_e    : fetch FSM state encoding
package fetch_unit_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer that parks a fetched instruction while the pipeline is frozen.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   load                   : capture load_instr / load_pc4 and mark full
//   clear                  : empty the buffer (wins over load)
//   load_instr, load_pc4   : data to capture
//   buf_instr, buf_pc4     : stored instruction and its fetch address + 4
//   buf_full               : buffer holds a valid entry
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc4,
  output logic [INSTR_W-1:0] buf_instr,
  output logic [31:0]        buf_pc4,
  output logic               buf_full
);

  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc4_q;
  logic               full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc4_q   <= '0;
      full_q  <= 1'b0;
    end else if (clear) begin
      full_q  <= 1'b0;
    end else if (load) begin
      instr_q <= load_instr;
      pc4_q   <= load_pc4;
      full_q  <= 1'b1;
    end
  end

  assign buf_instr = instr_q;
  assign buf_pc4   = pc4_q;
  assign buf_full  = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with a request/acknowledge port to variable-latency memory.
// Presents pc (fetch address + 4) / instruction / valid to the IF/ID register, honouring
// freeze (stall) and branch_taken (redirect).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   freeze                   : downstream stall, output not consumed this cycle
//   branch_taken, branch_addr: redirect fetch; current output is flushed downstream
//   imem_req, imem_addr      : memory request and address (stable while req is high)
//   imem_ack, imem_rdata     : memory response, data valid with ack
//   pc, instruction, valid   : presented fetch result
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [31:0]        branch_addr,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  req_pc4;

  logic               buf_load, buf_clear, buf_full;
  logic [INSTR_W-1:0] buf_instr;
  logic [31:0]        buf_pc4;

  // Wraps modulo 2^32.
  assign req_pc4 = req_addr_q + PC_STEP;

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (imem_rdata),
    .load_pc4   (req_pc4),
    .buf_instr  (buf_instr),
    .buf_pc4    (buf_pc4),
    .buf_full   (buf_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      req_addr_q <= RESET_PC;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      target_q   <= target_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    target_d   = target_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    if (branch_taken) begin
      buf_clear = 1'b1;
      // An un-acked request cannot be withdrawn; wait out its ack before redirecting.
      if ((state_q == StFetch || state_q == StDiscard) && !imem_ack) begin
        state_d  = StDiscard;
        target_d = branch_addr;
      end else begin
        req_addr_d = branch_addr;
        state_d    = StFetch;
      end
    end else begin
      case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (imem_ack) begin
            req_addr_d = req_pc4;
            if (freeze) begin
              buf_load = 1'b1;
              state_d  = StHold;
            end
          end
        end
        StHold: begin
          if (!freeze) begin
            buf_clear = 1'b1;
            state_d   = StFetch;
          end
        end
        StDiscard: begin
          if (imem_ack) begin
            req_addr_d = target_q;
            state_d    = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign imem_req  = (state_q == StFetch) || (state_q == StDiscard);
  assign imem_addr = req_addr_q;

  always_comb begin
    valid       = 1'b0;
    pc          = '0;
    instruction = '0;
    if (state_q == StFetch && imem_ack) begin
      valid       = 1'b1;
      pc          = req_pc4;
      instruction = imem_rdata;
    end else if (state_q == StHold) begin
      valid       = buf_full;
      pc          = buf_pc4;
      instruction = buf_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: ack after 'lat' wait cycles, data is a scrambled address.
  int unsigned lat = 0;
  int unsigned cnt = 0;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = mdat(imem_addr);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                       cnt <= 0;
  end

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .valid        (valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply controls at the falling edge, then settle before sampling.
  task automatic cyc(input logic f, input logic b, input logic [31:0] ba);
    @(negedge clk);
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    #1;
  endtask

  // Expect a presented instruction fetched from address a.
  task automatic expect_out(input string tag, input logic [31:0] a);
    check({tag, ".valid"}, {31'd0, valid}, 32'd1);
    check({tag, ".pc"}, pc, a + 32'd4);
    check({tag, ".instr"}, instruction, mdat(a));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, {31'd0, valid}, 32'd0);
    check({tag, ".pc"}, pc, 32'd0);
    check({tag, ".instr"}, instruction, 32'd0);
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
    check({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    check({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 32'h0);
    expect_req("rst", 1'b0, 32'h0);
    expect_idle("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_req("c0", 1'b0, 32'h0);
    expect_idle("c0");

    // Zero-wait streaming
    cyc(1'b0, 1'b0, 32'h0); expect_req("c1", 1'b1, 32'h0);  expect_out("c1", 32'h0);
    cyc(1'b0, 1'b0, 32'h0); expect_req("c2", 1'b1, 32'h4);  expect_out("c2", 32'h4);
    cyc(1'b0, 1'b0, 32'h0); expect_req("c3", 1'b1, 32'h8);  expect_out("c3", 32'h8);
    cyc(1'b0, 1'b0, 32'h0); expect_req("c4", 1'b1, 32'hC);  expect_out("c4", 32'hC);

    // Freeze for 3 cycles starting at the ack of 0x10
    cyc(1'b1, 1'b0, 32'h0); expect_req("fz0", 1'b1, 32'h10); expect_out("fz0", 32'h10);
    cyc(1'b1, 1'b0, 32'h0); expect_req("fz1", 1'b0, 32'h14); expect_out("fz1", 32'h10);
    cyc(1'b1, 1'b0, 32'h0); expect_req("fz2", 1'b0, 32'h14); expect_out("fz2", 32'h10);
    cyc(1'b0, 1'b0, 32'h0); expect_req("fzr", 1'b0, 32'h14); expect_out("fzr", 32'h10);
    cyc(1'b0, 1'b0, 32'h0); expect_req("fzn", 1'b1, 32'h14); expect_out("fzn", 32'h14);

    // Branch coinciding with a freeze ack: no HOLD, redirect next cycle
    cyc(1'b1, 1'b1, 32'h200); expect_req("bfa", 1'b1, 32'h18); expect_out("bfa", 32'h18);
    cyc(1'b0, 1'b0, 32'h0);   expect_req("bfb", 1'b1, 32'h200); expect_out("bfb", 32'h200);

    // Branch during HOLD
    cyc(1'b1, 1'b0, 32'h0);   expect_req("bh0", 1'b1, 32'h204); expect_out("bh0", 32'h204);
    cyc(1'b1, 1'b1, 32'h200); expect_req("bh1", 1'b0, 32'h208); expect_out("bh1", 32'h204);
    cyc(1'b0, 1'b0, 32'h0);   expect_req("bh2", 1'b1, 32'h200); expect_out("bh2", 32'h200);

    // Two-cycle memory: valid every other cycle, address stable until ack
    @(negedge clk); lat = 1;
    freeze = 1'b0; branch_taken = 1'b0; #1;
    expect_req("l0", 1'b1, 32'h204); expect_idle("l0");
    cyc(1'b0, 1'b0, 32'h0); expect_req("l1", 1'b1, 32'h204); expect_out("l1", 32'h204);
    cyc(1'b0, 1'b0, 32'h0); expect_req("l2", 1'b1, 32'h208); expect_idle("l2");
    cyc(1'b0, 1'b0, 32'h0); expect_req("l3", 1'b1, 32'h208); expect_out("l3", 32'h208);
    cyc(1'b0, 1'b0, 32'h0); expect_req("l4", 1'b1, 32'h20C); expect_idle("l4");
    // Branch on an ack cycle redirects directly
    cyc(1'b0, 1'b1, 32'h20); expect_req("l5", 1'b1, 32'h20C); expect_out("l5", 32'h20C);

    // Three-cycle memory: branch while 0x20 is in flight, overwritten in DISCARD
    @(negedge clk); lat = 2;
    freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80; #1;
    expect_req("d0", 1'b1, 32'h20); expect_idle("d0");
    cyc(1'b0, 1'b1, 32'h100); expect_req("d1", 1'b1, 32'h20); expect_idle("d1");
    cyc(1'b0, 1'b0, 32'h0);   expect_req("d2", 1'b1, 32'h20); expect_idle("d2");
    check("d2.ack", {31'd0, imem_ack}, 32'd1);
    cyc(1'b0, 1'b0, 32'h0);   expect_req("d3", 1'b1, 32'h100); expect_idle("d3");
    cyc(1'b0, 1'b0, 32'h0);   expect_req("d4", 1'b1, 32'h100); expect_idle("d4");
    cyc(1'b0, 1'b0, 32'h0);   expect_req("d5", 1'b1, 32'h100); expect_out("d5", 32'h100);

    // Reset pulse during DISCARD
    cyc(1'b0, 1'b1, 32'h400); expect_req("r0", 1'b1, 32'h104); expect_idle("r0");
    @(negedge clk);
    branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    expect_req("r1", 1'b0, 32'h0); expect_idle("r1");
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_req("r2", 1'b0, 32'h0); expect_idle("r2");
    @(negedge clk); lat = 0; #1;
    expect_req("r3", 1'b1, 32'h0); expect_out("r3", 32'h0);

    // Address wrap at the top of memory
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC); expect_req("w0", 1'b1, 32'h4); expect_out("w0", 32'h4);
    cyc(1'b0, 1'b0, 32'h0); expect_req("w1", 1'b1, 32'hFFFF_FFFC);
    check("w1.pc", pc, 32'h0);
    check("w1.instr", instruction, mdat(32'hFFFF_FFFC));
    cyc(1'b0, 1'b0, 32'h0); expect_req("w2", 1'b1, 32'h0); expect_out("w2", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
